// File: rtl/spi_pixel_writer_if.sv
// rtl/spi_pixel_writer_if.sv - SPI pins and display pixel-write port of spi_pixel_writer
interface spi_pixel_writer_if;
  logic        sclk;
  logic        sdi;
  logic        cs_n;
  logic        write_en;
  logic [5:0]  write_x;
  logic [5:0]  write_y;
  logic [11:0] write_color;
  logic        busy;
  logic        frame_err;

  modport master (
    output sclk, sdi, cs_n,
    input  write_en, write_x, write_y, write_color, busy, frame_err
  );

  modport slave (
    input  sclk, sdi, cs_n,
    output write_en, write_x, write_y, write_color, busy, frame_err
  );
endinterface

// File: rtl/spi_pixel_writer.sv
// rtl/spi_pixel_writer.sv - SPI command decoder driving the display pixel write port
module spi_pixel_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int CLEAR_GAP   = 16
) (
  input logic            clk_in,
  input logic            reset,
  spi_pixel_writer_if.slave bus
);
  localparam int GW = $clog2(CLEAR_GAP);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, cs_sync;
  logic sclk_prev, cs_prev;
  logic sclk_s, sdi_s, cs_s;

  // Only the low 7 bits are stored; the full byte is formed with the incoming bit.
  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  b0, b2;
  logic [5:0]  y_reg;
  logic [11:0] pos;
  logic [GW-1:0] gap_cnt;

  logic        wr_en, err;
  logic [5:0]  wr_x, wr_y;
  logic [11:0] wr_color;

  logic sclk_rise, cs_rise, byte_done, pkt_done;
  logic [7:0] new_byte;
  logic fire_pixel, start_sweep, sweep_tick, err_set;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  always_comb begin
    sclk_rise = sclk_s & ~sclk_prev & ~cs_s;
    cs_rise   = cs_s & ~cs_prev;
    new_byte  = {shift_reg, sdi_s};
    byte_done = sclk_rise && (bit_cnt == 3'd7);
    pkt_done  = byte_done && (byte_cnt == 2'd3);
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    fire_pixel  = 1'b0;
    start_sweep = 1'b0;
    sweep_tick  = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_done) begin
          case (b0[7:6])
            2'b01: fire_pixel = 1'b1;
            2'b10: begin
              start_sweep = 1'b1;
              state_next  = SWEEP;
            end
            2'b11: err_set = 1'b1;
            default: ;
          endcase
        end
      end
      SWEEP: begin
        // Anything but a NOP arriving mid-sweep is dropped and flagged.
        if (pkt_done && (b0[7:6] != 2'b00)) err_set = 1'b1;
        if (wr_en && (wr_x == 6'd63) && (wr_y == 6'd63)) state_next = IDLE;
        else if (gap_cnt == GW'(CLEAR_GAP - 1)) sweep_tick = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (byte_done && (byte_cnt == 2'd1) && (new_byte[7:6] != 2'b00)) err_set = 1'b1;
    if (cs_rise && ((bit_cnt != 3'd0) || (byte_cnt != 2'd0))) err_set = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      b0        <= '0;
      y_reg     <= '0;
      b2        <= '0;
      pos       <= '0;
      gap_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_color  <= '0;
      err       <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      wr_en     <= 1'b0;

      if (sclk_rise) begin
        shift_reg <= new_byte[6:0];
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0:    b0    <= new_byte;
            2'd1:    y_reg <= new_byte[5:0];
            2'd2:    b2    <= new_byte;
            default: ;
          endcase
        end
      end
      if (cs_rise) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      if (fire_pixel) begin
        wr_en    <= 1'b1;
        wr_x     <= b0[5:0];
        wr_y     <= y_reg;
        wr_color <= {b2, new_byte[7:4]};
      end
      if (start_sweep) begin
        wr_en    <= 1'b1;
        wr_x     <= '0;
        wr_y     <= '0;
        wr_color <= {b2, new_byte[7:4]};
        pos      <= 12'd1;
        gap_cnt  <= '0;
      end
      // pos is {y, x}, so x is the fast-moving coordinate.
      if (sweep_tick) begin
        wr_en        <= 1'b1;
        {wr_y, wr_x} <= pos;
        pos          <= pos + 12'd1;
        gap_cnt      <= '0;
      end else if (state == SWEEP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end

      if (err_set) err <= 1'b1;
    end
  end

  assign bus.write_en    = wr_en;
  assign bus.write_x     = wr_x;
  assign bus.write_y     = wr_y;
  assign bus.write_color = wr_color;
  assign bus.busy        = (state == SWEEP);
  assign bus.frame_err   = err;
endmodule

// File: doc/spi_pixel_writer.md
Name: spi_pixel_writer

Overview:
- SPI command decoder that drives the display block's pixel write port (write_en/write_x/write_y/write_color) from an external SPI controller.
- Replaces the internal pattern generator as the producer of pixel writes.
- Sits between the SPI pins and the display instance in the top level.
- Runs entirely in the clk_in domain; oversamples sclk/sdi/cs_n through synchronizers.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the sclk/sdi/cs_n synchronizers (min 2).
- CLEAR_GAP, 16, clk_in cycles between consecutive writes during a clear sweep (min 2).

Ports:
- clk_in  in  1  system clock (internal oscillator).
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, async, mode 0: sample on rising edge.
- sdi  in  1  SPI data, MSB first.
- cs_n  in  1  SPI chip select, active low.
- write_en  out  1  one-cycle pixel write strobe to display.
- write_x  out  6  pixel column, valid while write_en=1.
- write_y  out  6  pixel row, valid while write_en=1.
- write_color  out  12  {RRRR,GGGG,BBBB}, valid while write_en=1.
- busy  out  1  clear sweep in progress.
- frame_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - write_en=0, write_x=0, write_y=0, write_color=0.
  - busy=0, frame_err=0.
  - Shift register, bit counter and byte counter cleared; FSM in IDLE.
  - Synchronizer flops reset to sclk=0, sdi=0, cs_n=1.
- Input sampling:
  - sclk, sdi and cs_n each pass through SYNC_STAGES flops.
  - An sclk rise is detected when the synchronized sclk is 1 and its previous value was 0, qualified by synchronized cs_n=0.
  - On a detected rise: shift_reg <= {shift_reg[6:0], sdi_sync}; bit_cnt increments.
- Byte assembly:
  - bit_cnt wraps 7->0 and completes a byte.
  - Bytes are numbered 0..3 within a packet; byte_cnt wraps 3->0.
  - Back-to-back packets are allowed within one cs_n-low window.
- Packet format, 4 bytes:
  - b0 = {op[1:0], x[5:0]}
  - b1 = {2'b00, y[5:0]}
  - b2 = {R[3:0], G[3:0]}
  - b3 = {B[3:0], 4'bxxxx}; the low nibble of b3 is ignored.
- Opcodes:
  - op=01 PIXEL: in the cycle after b3 completes, write_en=1 for exactly 1 cycle with the decoded x, y and {R,G,B}.
  - op=10 CLEAR: x and y are ignored. Enter SWEEP with busy=1 starting the cycle after b3 completes. Write the decoded color to every pixel, x-major (x 0..63 inner, y 0..63 outer). The first write_en is 1 cycle after b3 completes; each later write follows CLEAR_GAP cycles after the previous one. That gives 4096 strobes. busy falls in the cycle after the strobe for (63,63).
  - op=00 NOP: the packet is consumed and no write is issued.
  - op=11 reserved: the packet is consumed, frame_err <= 1, no write.
- FSM states:
  - IDLE: no sweep active; PIXEL writes are issued from here.
  - SWEEP: clear in progress.
  - IDLE -> SWEEP on a completed CLEAR packet.
  - SWEEP -> IDLE after the (63,63) write.
- Boundary conditions:
  - PIXEL or CLEAR packet completes while busy=1: the packet is dropped, frame_err <= 1, and the sweep continues unaffected.
  - Bytes keep shifting during a sweep. A NOP completing while busy=1 is not an error.
  - cs_n deasserts (synchronized rise) mid-packet: bit_cnt and byte_cnt clear, the partial packet is discarded, and frame_err <= 1 if bit_cnt!=0 or byte_cnt!=0.
  - cs_n deasserting mid-packet does not stop an active sweep.
  - b1[7:6]!=00: y=b1[5:0] is still used and frame_err <= 1.
  - frame_err is cleared only by reset.
  - Reset mid-sweep: the next cycle shows busy=0 and write_en=0, the sweep is abandoned, and no further strobes occur.
- Rates:
  - sclk must be <= clk_in/(2*(SYNC_STAGES+2)); faster input is out of scope.
  - Pixel writes can never be back-to-back: minimum spacing is 32 sclk edges.

Test Plan:
- PIXEL: bytes 0x45,0x0A,0xF3,0x90 -> single write_en pulse with write_x=5, write_y=10, write_color=0xF39; frame_err=0.
- Two PIXEL packets in one cs_n window (x=0,y=0,0x00F then x=63,y=63,0xFFF) -> exactly 2 strobes with those values in order.
- CLEAR: bytes 0x80,0x00,0x12,0x30 with CLEAR_GAP=16 -> busy=1; 4096 strobes 16 cycles apart, color=0x123 throughout; first strobe (0,0), 65th strobe (0,1), last strobe (63,63); then busy=0.
- PIXEL packet sent during a sweep -> no extra strobe, frame_err=1, sweep count still 4096.
- cs_n raised after 2 bytes, then a fresh PIXEL (x=1, y=2, 0x0F0) -> no strobe for the partial packet, frame_err=1, then one correct strobe (1,2,0x0F0).
- Reset asserted at sweep strobe #100 -> busy=0 and write_en=0 next cycle; no further strobes; outputs hold reset values.
